// File: rtl/beatmap_sequencer.sv
// Real-time beatmap player: 60 Hz frame divider, song-frame position, ROM fetch and note issue.
// Optional BEATMAP_LOOP_EN restarts the map at its end instead of entering DONE.
module beatmap_sequencer #(
  parameter int TICK_DIV = 833333,
  parameter int CNT_W    = 20,
  parameter int ADDR_W   = 8,
  parameter int TIME_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [TIME_W+3:0] rom_data,
  output logic              note_valid,
  output logic [3:0]        note_lanes,
  input  logic              note_ready,
  output logic              frame_tick,
  output logic [TIME_W-1:0] song_frame,
  output logic              busy,
  output logic              done
);

  // state    | meaning
  // IDLE     | stopped, waiting for start
  // FETCH    | rom_addr presented to the ROM
  // WAIT_ROM | ROM word valid, latch stamp and lanes
  // COUNT    | wait for song_frame >= stamp
  // ISSUE    | offer note, wait for note_ready
  // DONE     | end of song reached
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_ROM, S_COUNT, S_ISSUE, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  div_cnt;
  logic [TIME_W-1:0] stamp;
  logic [3:0]        lanes;
  logic              start_ok, handshake, last_addr, end_marker, song_end;
  logic              div_en, div_wrap;

  assign start_ok   = start && !abort && (state == S_IDLE || state == S_DONE);
  assign handshake  = (state == S_ISSUE) && note_ready && !abort;
  assign last_addr  = &rom_addr;
  assign end_marker = (state == S_WAIT_ROM) && (rom_data[3:0] == 4'd0) && !abort;
  assign song_end   = end_marker || (handshake && last_addr);
  assign div_en     = busy && !pause;
  assign div_wrap   = div_en && (div_cnt == DIV_LAST);
  assign note_lanes = lanes;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) state_nxt = S_FETCH;
        S_FETCH:        state_nxt = S_WAIT_ROM;
        S_WAIT_ROM: begin
          if (rom_data[3:0] == 4'd0) begin
`ifdef BEATMAP_LOOP_EN
            state_nxt = S_FETCH;
`else
            state_nxt = S_DONE;
`endif
          end else begin
            state_nxt = S_COUNT;
          end
        end
        S_COUNT:        if (song_frame >= stamp) state_nxt = S_ISSUE;
        S_ISSUE: begin
          if (note_ready) begin
`ifdef BEATMAP_LOOP_EN
            state_nxt = S_FETCH;
`else
            state_nxt = last_addr ? S_DONE : S_FETCH;
`endif
          end
        end
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state != S_IDLE) && (state != S_DONE);
    done       = (state == S_DONE);
    note_valid = (state == S_ISSUE);
  end

  // Divider keeps running through ISSUE stalls so late issues never shift later notes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      frame_tick <= 1'b0;
      song_frame <= '0;
      rom_addr   <= '0;
      stamp      <= '0;
      lanes      <= '0;
    end else begin
      if (start_ok) begin
        div_cnt    <= '0;
        frame_tick <= 1'b0;
        song_frame <= '0;
        rom_addr   <= '0;
      end else begin
        frame_tick <= div_wrap;
        if (div_en) div_cnt <= div_wrap ? '0 : div_cnt + CNT_W'(1);
`ifdef BEATMAP_LOOP_EN
        if (song_end) begin
          song_frame <= '0;
          rom_addr   <= '0;
        end else begin
          if (div_wrap && song_frame != '1) song_frame <= song_frame + TIME_W'(1);
          if (handshake) rom_addr <= rom_addr + ADDR_W'(1);
        end
`else
        if (div_wrap && song_frame != '1) song_frame <= song_frame + TIME_W'(1);
        if (handshake && !song_end) rom_addr <= rom_addr + ADDR_W'(1);
`endif
      end
      if (state == S_WAIT_ROM) begin
        stamp <= rom_data[TIME_W+3:4];
        lanes <= rom_data[3:0];
      end
    end
  end

endmodule

// File: tb/tb_beatmap_sequencer.sv
// Directed bench for beatmap_sequencer with TICK_DIV=4 and a 4-word ROM (ADDR_W=2).
module tb_beatmap_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, pause, abort, note_ready;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data;
  logic        note_valid, frame_tick, busy, done;
  logic [3:0]  note_lanes;
  logic [11:0] song_frame;
  logic [15:0] rom_mem [4];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  beatmap_sequencer #(.TICK_DIV(4), .CNT_W(4), .ADDR_W(2), .TIME_W(12)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .rom_addr(rom_addr), .rom_data(rom_data), .note_valid(note_valid),
    .note_lanes(note_lanes), .note_ready(note_ready), .frame_tick(frame_tick),
    .song_frame(song_frame), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 200 && !note_valid; i++) tick();
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; note_ready = 1'b1;
    rom_mem[0] = 16'h0021; rom_mem[1] = 16'h0026; rom_mem[2] = 16'h0000; rom_mem[3] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_note_valid", 32'(note_valid), 32'd0);
    chk("rst_note_lanes", 32'(note_lanes), 32'd0);
    chk("rst_frame_tick", 32'(frame_tick), 32'd0);
    chk("rst_song_frame", 32'(song_frame), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    // Basic map: two chord notes at stamp 2, then end marker
    do_start();
    chk("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 20 && !frame_tick; i++) tick();
    chk("t1_first_tick_cyc", 32'(cyc), 32'd5);
    wait_valid();
    chk("t1_n0_cyc", 32'(cyc), 32'd10);
    chk("t1_n0_lanes", 32'(note_lanes), 32'h1);
    chk("t1_n0_frame", 32'(song_frame), 32'd2);
    tick();
    chk("t1_after_hs_valid", 32'(note_valid), 32'd0);
    chk("t1_after_hs_addr", 32'(rom_addr), 32'd1);
    wait_valid();
    chk("t1_n1_cyc", 32'(cyc), 32'd14);
    chk("t1_n1_lanes", 32'(note_lanes), 32'h6);
`ifdef BEATMAP_LOOP_EN
    for (int i = 0; i < 20 && rom_addr != 2'd0; i++) tick();
    chk("t1_loop_cyc", 32'(cyc), 32'd17);
    chk("t1_loop_frame", 32'(song_frame), 32'd0);
    chk("t1_loop_busy", 32'(busy), 32'd1);
    wait_valid();
    chk("t1_loop_reissue_cyc", 32'(cyc), 32'd26);
    chk("t1_loop_reissue_lanes", 32'(note_lanes), 32'h1);
    chk("t1_loop_done", 32'(done), 32'd0);
    do_abort();
`else
    for (int i = 0; i < 20 && !done; i++) tick();
    chk("t1_done_cyc", 32'(cyc), 32'd17);
    chk("t1_done_busy", 32'(busy), 32'd0);
    chk("t1_done_addr", 32'(rom_addr), 32'd2);
    chk("t1_done_frame", 32'(song_frame), 32'd4);
    repeat (10) tick();
    chk("t1_frozen_frame", 32'(song_frame), 32'd4);
    chk("t1_frozen_tick", 32'(frame_tick), 32'd0);
`endif

    // Backpressure during ISSUE
    rom_mem[0] = 16'h0013; rom_mem[1] = 16'h0000;
    note_ready = 1'b0;
    do_start();
    wait_valid();
    chk("t2_issue_cyc", 32'(cyc), 32'd6);
    begin
      logic stable;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (note_valid !== 1'b1 || note_lanes !== 4'h3 || rom_addr !== 2'd0) stable = 1'b0;
      end
      chk("t2_stall_stable", 32'(stable), 32'd1);
    end
    chk("t2_stall_frame", 32'(song_frame), 32'd3);
    note_ready = 1'b1;
    tick();
    chk("t2_release_valid", 32'(note_valid), 32'd0);
    chk("t2_release_addr", 32'(rom_addr), 32'd1);
    do_abort();
    chk("t2_abort_busy", 32'(busy), 32'd0);

    // Pause 12 cycles before stamp 3, then abort during ISSUE
    rom_mem[0] = 16'h0034; rom_mem[1] = 16'h0000;
    note_ready = 1'b0;
    do_start();
    repeat (5) tick();
    pause = 1'b1;
    repeat (11) tick();
    chk("t3_pause_frame", 32'(song_frame), 32'd1);
    chk("t3_pause_tick", 32'(frame_tick), 32'd0);
    tick();
    pause = 1'b0;
    wait_valid();
    chk("t3_issue_cyc", 32'(cyc), 32'd26);
    chk("t3_issue_lanes", 32'(note_lanes), 32'h4);
    do_abort();
    chk("t4_abort_valid", 32'(note_valid), 32'd0);
    chk("t4_abort_busy", 32'(busy), 32'd0);
    chk("t4_abort_frame_hold", 32'(song_frame), 32'd3);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t4_abort_beats_start", 32'(busy), 32'd0);
    do_start();
    chk("t4_restart_frame", 32'(song_frame), 32'd0);
    chk("t4_restart_addr", 32'(rom_addr), 32'd0);
    wait_valid();
    chk("t4_replay_cyc", 32'(cyc), 32'd14);
    chk("t4_replay_frame", 32'(song_frame), 32'd3);
    do_abort();

    // Last ROM address ends the song
    rom_mem[0] = 16'h0001; rom_mem[1] = 16'h0002; rom_mem[2] = 16'h0004; rom_mem[3] = 16'h0008;
    note_ready = 1'b1;
    do_start();
    wait_valid();
    chk("t5_n0_cyc", 32'(cyc), 32'd4);
    tick(); wait_valid();
    chk("t5_n1_cyc", 32'(cyc), 32'd8);
    tick(); wait_valid();
    tick(); wait_valid();
    chk("t5_n3_cyc", 32'(cyc), 32'd16);
    chk("t5_n3_lanes", 32'(note_lanes), 32'h8);
    chk("t5_n3_addr", 32'(rom_addr), 32'd3);
    tick();
`ifdef BEATMAP_LOOP_EN
    chk("t5_wrap_addr", 32'(rom_addr), 32'd0);
    chk("t5_wrap_frame", 32'(song_frame), 32'd0);
    chk("t5_wrap_busy", 32'(busy), 32'd1);
`else
    chk("t5_end_done", 32'(done), 32'd1);
    chk("t5_end_addr", 32'(rom_addr), 32'd3);
    chk("t5_end_valid", 32'(note_valid), 32'd0);
`endif
    do_abort();

    // Ignored start while busy, then async reset mid-COUNT
    rom_mem[0] = 16'h0034; rom_mem[1] = 16'h0000;
    note_ready = 1'b0;
    do_start();
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_start_ignored_busy", 32'(busy), 32'd1);
    chk("t6_start_ignored_frame", 32'(song_frame), 32'd1);
    repeat (2) tick();
    chk("t6_divider_kept", 32'(song_frame), 32'd2);
    tick();
    #3 reset = 1'b1;
    #1;
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_frame", 32'(song_frame), 32'd0);
    chk("t6_async_lanes", 32'(note_lanes), 32'd0);
    chk("t6_async_tick", 32'(frame_tick), 32'd0);
    chk("t6_async_valid", 32'(note_valid), 32'd0);
    chk("t6_async_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
